// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared coin and dispenser-state types for the change dispenser
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_NICKEL,
        COIN_DIME,
        COIN_QUARTER
    } coin_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_GAP
    } disp_state_e;

    // Coin values in nickel units; rem and change use the same 3-bit scale.
    localparam logic [2:0] NICKEL_VAL  = 3'd1;
    localparam logic [2:0] DIME_VAL    = 3'd2;
    localparam logic [2:0] QUARTER_VAL = 3'd5;

    function automatic logic [2:0] coin_value(input coin_e c);
        case (c)
            COIN_NICKEL:  return NICKEL_VAL;
            COIN_DIME:    return DIME_VAL;
            COIN_QUARTER: return QUARTER_VAL;
            default:      return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_select.sv
// rtl/change_select.sv - greedy, inventory-aware coin choice for the remaining change
module change_select
    import vend_pkg::*;
#(
    parameter int INV_W = 8
) (
    input  logic [2:0]       rem,
    input  logic [INV_W-1:0] cnt_nickel,
    input  logic [INV_W-1:0] cnt_dime,
    input  logic [INV_W-1:0] cnt_quarter,
    output coin_e            coin
);

    // Largest coin that still fits and is in stock; COIN_NONE means nothing fits.
    always_comb begin
        coin = COIN_NONE;
        if (rem >= QUARTER_VAL && cnt_quarter != '0) begin
            coin = COIN_QUARTER;
        end else if (rem >= DIME_VAL && cnt_dime != '0) begin
            coin = COIN_DIME;
        end else if (rem >= NICKEL_VAL && cnt_nickel != '0) begin
            coin = COIN_NICKEL;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - drives coin-hopper solenoids to pay change, with inventory and one pending request
module change_dispenser
    import vend_pkg::*;
#(
    parameter int INV_W      = 8,
    parameter int TIMEOUT    = 1000,
    parameter int GAP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soda,
    input  logic [2:0]       change,
    input  logic             coin_ack,
    input  logic             inv_load,
    input  logic [INV_W-1:0] inv_nickel,
    input  logic [INV_W-1:0] inv_dime,
    input  logic [INV_W-1:0] inv_quarter,
    input  logic             err_clr,
    output logic             eject_nickel,
    output logic             eject_dime,
    output logic             eject_quarter,
    output logic             busy,
    output logic             done,
    output logic             err_short,
    output logic             err_timeout,
    output logic             err_overrun,
    output logic [INV_W-1:0] cnt_nickel,
    output logic [INV_W-1:0] cnt_dime,
    output logic [INV_W-1:0] cnt_quarter
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    disp_state_e   state;
    logic [2:0]    rem;
    logic          pend_valid;
    logic [2:0]    pend_change;
    coin_e         cur_coin;
    coin_e         sel_coin;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] gcnt;
    logic          req;

    assign req  = soda && (change != 3'd0);
    assign busy = (state != ST_IDLE) || pend_valid;

    change_select #(.INV_W(INV_W)) u_select (
        .rem         (rem),
        .cnt_nickel  (cnt_nickel),
        .cnt_dime    (cnt_dime),
        .cnt_quarter (cnt_quarter),
        .coin        (sel_coin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            rem           <= 3'd0;
            pend_valid    <= 1'b0;
            pend_change   <= 3'd0;
            cur_coin      <= COIN_NONE;
            tcnt          <= '0;
            gcnt          <= '0;
            eject_nickel  <= 1'b0;
            eject_dime    <= 1'b0;
            eject_quarter <= 1'b0;
            done          <= 1'b0;
            err_short     <= 1'b0;
            err_timeout   <= 1'b0;
            err_overrun   <= 1'b0;
            cnt_nickel    <= '0;
            cnt_dime      <= '0;
            cnt_quarter   <= '0;
        end else begin
            done <= 1'b0;

            // Clear first so any error raised below in the same cycle survives.
            if (err_clr) begin
                err_short   <= 1'b0;
                err_timeout <= 1'b0;
                err_overrun <= 1'b0;
            end

            if (req && state != ST_IDLE) begin
                if (!pend_valid) begin
                    pend_valid  <= 1'b1;
                    pend_change <= change;
                end else begin
                    err_overrun <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (inv_load) begin
                        cnt_nickel  <= inv_nickel;
                        cnt_dime    <= inv_dime;
                        cnt_quarter <= inv_quarter;
                    end
                    if (pend_valid) begin
                        rem        <= pend_change;
                        state      <= ST_SELECT;
                        pend_valid <= req;
                        if (req) begin
                            pend_change <= change;
                        end
                    end else if (req) begin
                        rem   <= change;
                        state <= ST_SELECT;
                    end
                end

                ST_SELECT: begin
                    if (rem == 3'd0) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else if (sel_coin == COIN_NONE) begin
                        err_short <= 1'b1;
                        rem       <= 3'd0;
                        state     <= ST_IDLE;
                    end else begin
                        cur_coin      <= sel_coin;
                        tcnt          <= '0;
                        eject_nickel  <= (sel_coin == COIN_NICKEL);
                        eject_dime    <= (sel_coin == COIN_DIME);
                        eject_quarter <= (sel_coin == COIN_QUARTER);
                        state         <= ST_EJECT;
                    end
                end

                ST_EJECT: begin
                    if (coin_ack) begin
                        eject_nickel  <= 1'b0;
                        eject_dime    <= 1'b0;
                        eject_quarter <= 1'b0;
                        rem           <= rem - coin_value(cur_coin);
                        case (cur_coin)
                            COIN_NICKEL:  if (cnt_nickel  != '0) cnt_nickel  <= cnt_nickel  - 1'b1;
                            COIN_DIME:    if (cnt_dime    != '0) cnt_dime    <= cnt_dime    - 1'b1;
                            COIN_QUARTER: if (cnt_quarter != '0) cnt_quarter <= cnt_quarter - 1'b1;
                            default: ;
                        endcase
                        gcnt  <= '0;
                        state <= ST_GAP;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        // Hopper presumed jammed or empty: write it off and retry smaller coins.
                        eject_nickel  <= 1'b0;
                        eject_dime    <= 1'b0;
                        eject_quarter <= 1'b0;
                        err_timeout   <= 1'b1;
                        case (cur_coin)
                            COIN_NICKEL:  cnt_nickel  <= '0;
                            COIN_DIME:    cnt_dime    <= '0;
                            COIN_QUARTER: cnt_quarter <= '0;
                            default: ;
                        endcase
                        state <= ST_SELECT;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                ST_GAP: begin
                    if (gcnt == GW'(GAP_CYCLES - 1)) begin
                        state <= ST_SELECT;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - self-checking bench for change_dispenser
module tb_change_dispenser;

    localparam int INV_W  = 8;
    localparam int TO     = 50;
    localparam int GAP    = 4;
    localparam int BUDGET = 20 * (TO + 20);
    localparam int DC     = -2;
    localparam int NV     = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             soda = 1'b0;
    logic [2:0]       change = 3'd0;
    logic             coin_ack = 1'b0;
    logic             inv_load = 1'b0;
    logic [INV_W-1:0] inv_nickel = '0;
    logic [INV_W-1:0] inv_dime = '0;
    logic [INV_W-1:0] inv_quarter = '0;
    logic             err_clr = 1'b0;
    logic             eject_nickel, eject_dime, eject_quarter;
    logic             busy, done, err_short, err_timeout, err_overrun;
    logic [INV_W-1:0] cnt_nickel, cnt_dime, cnt_quarter;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    change_dispenser #(.INV_W(INV_W), .TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .soda(soda), .change(change), .coin_ack(coin_ack),
        .inv_load(inv_load), .inv_nickel(inv_nickel), .inv_dime(inv_dime),
        .inv_quarter(inv_quarter), .err_clr(err_clr),
        .eject_nickel(eject_nickel), .eject_dime(eject_dime), .eject_quarter(eject_quarter),
        .busy(busy), .done(done), .err_short(err_short), .err_timeout(err_timeout),
        .err_overrun(err_overrun), .cnt_nickel(cnt_nickel), .cnt_dime(cnt_dime),
        .cnt_quarter(cnt_quarter)
    );

    typedef struct {
        int ld, n, d, q, chg, jam;
        int dn, sh, to, en, ed, eq;
        int first_ej, idle_at, first_len;
    } vec_t;

    vec_t  vecs[NV];
    string vseq[NV];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chks(input string name, input string got, input string exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got '%s' expected '%s'", name, got, exp);
        end
    endtask

    // Coin-by-coin payout as the rules describe it, using plain counts.
    function automatic void model(input int n0, input int d0, input int q0, input int chg,
                                  input int jam, output string seq, output int dn,
                                  output int sh, output int to, output int n,
                                  output int d, output int q);
        int    cnt[3];
        int    val[3];
        int    rem;
        bit    picked;
        string letters;
        letters = "NDQ";
        val = '{1, 2, 5};
        cnt[0] = n0; cnt[1] = d0; cnt[2] = q0;
        seq = ""; rem = chg; sh = 0; to = 0;
        while (rem > 0 && sh == 0) begin
            picked = 0;
            for (int c = 2; c >= 0; c--) begin
                if (!picked && rem >= val[c] && cnt[c] > 0) begin
                    picked = 1;
                    seq = {seq, letters.substr(c, c)};
                    if (jam[c]) begin
                        to = 1;
                        cnt[c] = 0;
                    end else begin
                        cnt[c] = cnt[c] - 1;
                        rem = rem - val[c];
                    end
                end
            end
            if (!picked) sh = 1;
        end
        dn = (rem == 0) ? 1 : 0;
        n = cnt[0]; d = cnt[1]; q = cnt[2];
    endfunction

    task automatic load(input int n, input int d, input int q);
        @(negedge clk);
        inv_load = 1'b1; err_clr = 1'b1;
        inv_nickel = INV_W'(n); inv_dime = INV_W'(d); inv_quarter = INV_W'(q);
        @(negedge clk);
        inv_load = 1'b0; err_clr = 1'b0;
    endtask

    // Acts as the hopper: acks each new eject after `delay` samples unless that coin is jammed.
    task automatic serve(input int jam, input int delay, output string seq, output int dones,
                         output int first_ej, output int idle_at, output int first_len);
        int         wait_cnt = 0;
        int         idx = 1;
        bit         fin = 0;
        bit         jam_cur = 0;
        logic [2:0] prev = 3'b000;
        logic [2:0] ej;
        seq = ""; dones = 0; first_ej = -1; idle_at = -1; first_len = 0;
        while (!fin) begin
            ej = {eject_quarter, eject_dime, eject_nickel};
            if (done) dones++;
            coin_ack = 1'b0;
            if (ej != 3'b000 && prev == 3'b000) begin
                if (first_ej < 0) first_ej = idx;
                case (ej)
                    3'b001:  begin seq = {seq, "N"}; jam_cur = jam[0]; end
                    3'b010:  begin seq = {seq, "D"}; jam_cur = jam[1]; end
                    3'b100:  begin seq = {seq, "Q"}; jam_cur = jam[2]; end
                    default: begin seq = {seq, "?"}; jam_cur = 1'b1; end
                endcase
                wait_cnt = delay;
            end
            if (ej != 3'b000 && seq.len() == 1) first_len++;
            if (ej != 3'b000 && !jam_cur && wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) coin_ack = 1'b1;
            end
            prev = ej;
            if (!busy) begin
                idle_at = idx;
                fin = 1;
            end else if (idx >= BUDGET) begin
                checks++;
                errors++;
                $display("FAIL serve_timeout: busy still %0d after %0d cycles, required 0", busy, idx);
                fin = 1;
            end else begin
                @(negedge clk);
                idx++;
            end
        end
        coin_ack = 1'b0;
    endtask

    task automatic run_txn(input int chg, input int jam, input int delay, output string seq,
                           output int dones, output int first_ej, output int idle_at,
                           output int first_len);
        @(negedge clk);
        soda = 1'b1; change = 3'(chg);
        @(negedge clk);
        soda = 1'b0; change = 3'd0;
        serve(jam, delay, seq, dones, first_ej, idle_at, first_len);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        string seq, eseq, tag;
        int dones, fe, ia, fl;
        int n, d, q, chg, jam, dl;
        int edn, esh, eto, en, ed, eq;

        //         ld n  d  q  chg jam   dn sh to  en ed eq  first_ej idle_at first_len
        vecs[0] = '{1, 5, 5, 5, 3, 3'b000, 1, 0, 0, 4, 4, 5, 2,  DC, DC};
        vseq[0] = "DN";
        vecs[1] = '{1, 5, 5, 5, 7, 3'b000, 1, 0, 0, 5, 4, 4, 2,  DC, DC};
        vseq[1] = "QD";
        vecs[2] = '{1, 5, 0, 5, 2, 3'b000, 1, 0, 0, 3, 0, 5, DC, DC, DC};
        vseq[2] = "NN";
        vecs[3] = '{1, 0, 0, 5, 3, 3'b000, 0, 1, 0, 0, 0, 5, -1, 2,  DC};
        vseq[3] = "";
        vecs[4] = '{1, 5, 5, 5, 5, 3'b100, 1, 0, 1, 4, 3, 0, DC, DC, TO};
        vseq[4] = "QDDN";
        vecs[5] = '{1, 0, 5, 5, 6, 3'b000, 0, 1, 0, 0, 5, 4, DC, DC, DC};
        vseq[5] = "Q";
        vecs[6] = '{1, 1, 3, 0, 7, 3'b000, 1, 0, 0, 0, 0, 0, DC, DC, DC};
        vseq[6] = "DDDN";
        vecs[7] = '{1, 1, 1, 1, 7, 3'b000, 1, 0, 0, 1, 0, 0, DC, DC, DC};
        vseq[7] = "QD";
        vecs[8] = '{1, 2, 2, 2, 7, 3'b110, 0, 1, 1, 0, 0, 0, DC, DC, DC};
        vseq[8] = "QDNN";

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_outputs", int'({eject_nickel, eject_dime, eject_quarter, busy, done,
                                 err_short, err_timeout, err_overrun}), 0);
        chk("rst_counts", int'(cnt_nickel) + int'(cnt_dime) + int'(cnt_quarter), 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].ld != 0) load(vecs[i].n, vecs[i].d, vecs[i].q);
            run_txn(vecs[i].chg, vecs[i].jam, 3, seq, dones, fe, ia, fl);
            tag = $sformatf("vec%0d", i);
            chks({tag, "_seq"}, seq, vseq[i]);
            chk({tag, "_done"}, dones, vecs[i].dn);
            chk({tag, "_short"}, int'(err_short), vecs[i].sh);
            chk({tag, "_timeout"}, int'(err_timeout), vecs[i].to);
            chk({tag, "_cnt_n"}, int'(cnt_nickel), vecs[i].en);
            chk({tag, "_cnt_d"}, int'(cnt_dime), vecs[i].ed);
            chk({tag, "_cnt_q"}, int'(cnt_quarter), vecs[i].eq);
            if (vecs[i].first_ej != DC) chk({tag, "_first_eject"}, fe, vecs[i].first_ej);
            if (vecs[i].idle_at != DC) chk({tag, "_idle_at"}, ia, vecs[i].idle_at);
            if (vecs[i].first_len != DC) chk({tag, "_first_len"}, fl, vecs[i].first_len);
        end

        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 3); d = $urandom_range(0, 3); q = $urandom_range(0, 3);
            chg = $urandom_range(1, 7);
            jam = 0;
            for (int b = 0; b < 3; b++) if ($urandom_range(0, 3) == 0) jam |= (1 << b);
            dl = $urandom_range(1, 4);
            model(n, d, q, chg, jam, eseq, edn, esh, eto, en, ed, eq);
            load(n, d, q);
            run_txn(chg, jam, dl, seq, dones, fe, ia, fl);
            tag = $sformatf("rnd%0d", r);
            chks({tag, "_seq"}, seq, eseq);
            chk({tag, "_done"}, dones, edn);
            chk({tag, "_short"}, int'(err_short), esh);
            chk({tag, "_timeout"}, int'(err_timeout), eto);
            chk({tag, "_cnt_n"}, int'(cnt_nickel), en);
            chk({tag, "_cnt_d"}, int'(cnt_dime), ed);
            chk({tag, "_cnt_q"}, int'(cnt_quarter), eq);
        end

        // Pending request, two overruns, and an inventory load ignored while busy.
        load(5, 5, 5);
        @(negedge clk); soda = 1'b1; change = 3'd3;
        @(negedge clk); change = 3'd1;
        @(negedge clk); change = 3'd2;
        inv_load = 1'b1; inv_nickel = 9; inv_dime = 9; inv_quarter = 9;
        @(negedge clk); change = 3'd3; inv_load = 1'b0;
        @(negedge clk); soda = 1'b0; change = 3'd0;
        chk("pend_overrun", int'(err_overrun), 1);
        chk("pend_busy", int'(busy), 1);
        serve(0, 3, seq, dones, fe, ia, fl);
        chks("pend_seq", seq, "DNN");
        chk("pend_dones", dones, 2);
        chk("pend_short", int'(err_short), 0);
        chk("pend_cnt_n", int'(cnt_nickel), 3);
        chk("pend_cnt_d", int'(cnt_dime), 4);
        chk("pend_cnt_q", int'(cnt_quarter), 5);

        // Asynchronous reset while a quarter is being ejected.
        @(negedge clk); soda = 1'b1; change = 3'd5;
        @(negedge clk); soda = 1'b0; change = 3'd0;
        @(negedge clk);
        chk("arst_pre_eject_q", int'(eject_quarter), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_eject_q", int'(eject_quarter), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_overrun", int'(err_overrun), 0);
        chk("arst_cnt_q", int'(cnt_quarter), 0);
        @(negedge clk); rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
